// File: rtl/picomips_clk_pkg.sv
// picomips_clk_pkg: shared types and constants for the picoMIPS clock-enable logic.
package picomips_clk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} step_state_t;

    localparam int SYNC_STAGES  = 2;
    localparam int STEP_COUNT_W = 16;

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchroniser plus optional debounce (CPU_STEP_DEBOUNCE_EN).
// Without the macro the accepted level is a plain registered copy of the synchronised input.
module sync_debounce
    import picomips_clk_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic n_reset,
    input  logic i_raw,
    output logic o_db
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   r_db;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_db   = r_db;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end

`ifdef CPU_STEP_DEBOUNCE_EN
    // One extra bit so the counter can hold D itself: accept on the D+1th disagreeing edge.
    localparam logic [DEBOUNCE_BITS:0] D = {1'b1, {DEBOUNCE_BITS{1'b0}}};

    logic [DEBOUNCE_BITS:0] r_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_sync == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == D) begin
            r_cnt <= '0;
            r_db  <= w_sync;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_db <= 1'b0;
        else          r_db <= w_sync;
    end
`endif

endmodule

// File: rtl/cpu_step_control.sv
// cpu_step_control: run/step clock-enable generator for the picoMIPS core.
// Debounce of both inputs is enabled by defining CPU_STEP_DEBOUNCE_EN.
module cpu_step_control
    import picomips_clk_pkg::*;
#(
    parameter int DIV_FACTOR    = 24,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    btn_step,
    input  logic                    run_sw,
    output logic                    cpu_en,
    output logic                    running,
    output logic [STEP_COUNT_W-1:0] step_count
);

    logic                  w_btn_db;
    logic                  w_run_db;
    logic                  w_pulse;
    step_state_t           r_state;
    step_state_t           w_next;
    logic [DIV_FACTOR-1:0] r_rate;

    sync_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_btn (
        .clk    (clk),
        .n_reset(n_reset),
        .i_raw  (btn_step),
        .o_db   (w_btn_db)
    );

    sync_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_run (
        .clk    (clk),
        .n_reset(n_reset),
        .i_raw  (run_sw),
        .o_db   (w_run_db)
    );

    // RUN has priority over a simultaneous press; a run pulse is dropped on the exit cycle.
    always_comb begin
        w_next  = (r_state == IDLE) ? (w_run_db ? RUN : (w_btn_db ? HOLD : IDLE))
                : (r_state == HOLD) ? (w_btn_db ? HOLD : IDLE)
                :                     (w_run_db ? RUN : IDLE);
        w_pulse = (r_state == IDLE && !w_run_db && w_btn_db) ||
                  (r_state == RUN && w_run_db && (&r_rate));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= IDLE;
            r_rate     <= '0;
            cpu_en     <= 1'b0;
            running    <= 1'b0;
            step_count <= '0;
        end else begin
            r_state    <= w_next;
            r_rate     <= (r_state == RUN) ? r_rate + 1'b1 : '0;
            cpu_en     <= w_pulse;
            running    <= (w_next == RUN);
            step_count <= step_count + STEP_COUNT_W'(w_pulse);
        end
    end

endmodule

// File: tb/tb_cpu_step_control.sv
// tb_cpu_step_control: table-driven and sequence checks of cpu_step_control (DEBOUNCE_BITS=4, DIV_FACTOR=3).
module tb_cpu_step_control;

`ifdef CPU_STEP_DEBOUNCE_EN
    localparam int D = 16;
`else
    localparam int D = 0;
`endif
    localparam int L   = 3 + D;
    localparam int P9  = (D != 0) ? 2 : 0;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        btn_step = 1'b0;
    logic        run_sw = 1'b0;
    logic        cpu_en;
    logic        running;
    logic [15:0] step_count;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cpu_step_control #(.DIV_FACTOR(3), .DEBOUNCE_BITS(4)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .btn_step  (btn_step),
        .run_sw    (run_sw),
        .cpu_en    (cpu_en),
        .running   (running),
        .step_count(step_count)
    );

    typedef struct {
        logic btn;
        logic run;
        int   ncyc;
        int   exp_pulses;
        logic exp_running;
        int   exp_count;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_en) pulses++;
    endtask

    initial begin
        int first;
        int rise;
        int fall;
        for (int i = 0; i < 20; i++) begin
            btn_step = i[0];
            run_sw   = i[1];
            @(posedge clk);
            #1;
            check("reset_hold_outputs", int'(cpu_en) + int'(running) + int'(step_count), 0);
        end
        btn_step = 1'b0;
        run_sw   = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) tick();
        vecs = '{
            '{1'b0, 1'b0, 40,     0,  1'b0, 0},
            '{1'b1, 1'b0, 60,     1,  1'b0, 1},
            '{1'b0, 1'b0, 40,     0,  1'b0, 1},
            '{1'b1, 1'b0, 40,     1,  1'b0, 2},
            '{1'b1, 1'b1, 40,     0,  1'b0, 2},
            '{1'b0, 1'b1, L + 21, 2,  1'b1, 4},
            '{1'b1, 1'b1, 16,     2,  1'b1, 6},
            '{1'b0, 1'b1, 16,     2,  1'b1, 8},
            '{1'b0, 1'b0, 40,     P9, 1'b0, 8 + P9}
        };
        foreach (vecs[k]) begin
            btn_step = vecs[k].btn;
            run_sw   = vecs[k].run;
            pulses   = 0;
            repeat (vecs[k].ncyc) tick();
            check($sformatf("vec%0d_pulses", k), pulses, vecs[k].exp_pulses);
            check($sformatf("vec%0d_running", k), int'(running), int'(vecs[k].exp_running));
            check($sformatf("vec%0d_step_count", k), int'(step_count), vecs[k].exp_count);
        end
        exp_cnt = 8 + P9;
`ifdef CPU_STEP_DEBOUNCE_EN
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            btn_step = ~btn_step;
            repeat (5) tick();
        end
        btn_step = 1'b0;
        repeat (40) tick();
        check("bounce_pulses", pulses, 0);
        check("bounce_step_count", int'(step_count), exp_cnt);
`endif
        pulses   = 0;
        first    = -1;
        btn_step = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cpu_en && first < 0) first = i;
        end
        check("step_latency", first, L);
        check("step_single_pulse", pulses, 1);
        exp_cnt++;
        check("step_count_after_step", int'(step_count), exp_cnt);
        btn_step = 1'b0;
        repeat (40) tick();
        pulses = 0;
        rise   = -1;
        first  = -1;
        run_sw = 1'b1;
        for (int i = 0; i < 60 && first < 0; i++) begin
            tick();
            if (running && rise < 0) rise = i;
            if (cpu_en) first = i;
        end
        check("run_latency", rise, L);
        check("run_first_pulse", first, L + 8);
        run_sw = 1'b0;
        fall   = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!running && fall < 0) fall = i;
        end
        check("run_exit_latency", fall, L);
        check("run_pulse_total", pulses, (L + 8) / 8);
        exp_cnt += (L + 8) / 8;
        check("step_count_after_run", int'(step_count), exp_cnt);
        pulses = 0;
        run_sw = 1'b1;
        repeat (16) tick();
        run_sw = 1'b0;
        fall   = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!running && fall < 0) fall = i;
        end
        check("exit_pulse_suppressed", pulses, 1);
        check("exit_latency_suppress", fall, L);
        exp_cnt++;
        check("step_count_after_suppress", int'(step_count), exp_cnt);
        run_sw = 1'b1;
        rise   = -1;
        for (int i = 0; i < 60 && rise < 0; i++) begin
            tick();
            if (running) rise = i;
        end
        check("rerun_before_reset", rise, L);
        repeat (3) tick();
        #2 n_reset = 1'b0;
        #1;
        check("async_rst_cpu_en", int'(cpu_en), 0);
        check("async_rst_running", int'(running), 0);
        check("async_rst_step_count", int'(step_count), 0);
        repeat (3) @(posedge clk);
        #3 n_reset = 1'b1;
        pulses = 0;
        rise   = -1;
        first  = -1;
        for (int i = 0; i < 60 && first < 0; i++) begin
            tick();
            if (running && rise < 0) rise = i;
            if (cpu_en) first = i;
        end
        check("rst_rerun_latency", rise, L);
        check("rst_first_pulse", first, L + 8);
        check("rst_step_count", int'(step_count), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
